dff_reg: RTL and testbench

- Parameterised D flip-flop register with synchronous active-low reset, synchronous clear and stall (hold) controls.
- This is the generic state/pipeline register used across the SoC. Examples are the MMU page-walk state register and core pipeline latches.
- Control-tied instances (clear and stall both at DISABLE) behave as a plain resettable register.

---
 rtl/dff_reg_pkg.sv | 9 +
 rtl/dff_reg.sv | 26 ++
 tb/tb_dff_reg.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dff_reg_pkg.sv
// Shared control literals for tying off register controls across the SoC.
package dff_reg_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic TRUE    = 1'b1;
  localparam logic FALSE   = 1'b0;

endpackage

// File: rtl/dff_reg.sv
// Generic D register: synchronous active-low reset, synchronous clear, and stall (hold).
// Priority at each rising edge: reset, clear, stall, load d.
module dff_reg
  import dff_reg_pkg::*;
#(
  parameter int unsigned      WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             stall,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Conditional operators, rather than if/else, let an X on clear or stall reach q in simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= INIT;
    end else begin
      q <= (clear == ENABLE) ? INIT : ((stall == ENABLE) ? q : d);
    end
  end

endmodule

// File: tb/tb_dff_reg.sv
// Directed bench for dff_reg: a vector table on a 4-bit instance plus hand-written sequences
// for non-zero INIT, reset pulses between edges, and a 64-bit tied-off instance.
module tb_dff_reg;
  import dff_reg_pkg::*;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // 4-bit, INIT = 0
  logic       rst_n4, clear4, stall4;
  logic [3:0] d4, q4;
  dff_reg #(.WIDTH(4), .INIT(4'h0)) u_dut4 (
    .clk(clk), .rst_n(rst_n4), .clear(clear4), .stall(stall4), .d(d4), .q(q4)
  );

  // 8-bit, INIT = 5A
  logic       rst_n8, clear8, stall8;
  logic [7:0] d8, q8;
  dff_reg #(.WIDTH(8), .INIT(8'h5A)) u_dut8 (
    .clk(clk), .rst_n(rst_n8), .clear(clear8), .stall(stall8), .d(d8), .q(q8)
  );

  // 64-bit, controls tied off
  logic        rst_n64;
  logic [63:0] d64, q64;
  dff_reg #(.WIDTH(64), .INIT(64'h0)) u_dut64 (
    .clk(clk), .rst_n(rst_n64), .clear(DISABLE), .stall(DISABLE), .d(d64), .q(q64)
  );

  typedef struct {
    logic       rst_n;
    logic       clear;
    logic       stall;
    logic [3:0] d;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'hA, 4'h0};  // reset
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'hA, 4'hA};  // release -> load
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'h3, 4'h3};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'h9, 4'h3};  // stall x3
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'h9, 4'h3};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'h9, 4'h3};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'h9, 4'h9};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'h7, 4'h7};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'hC, 4'h0};  // clear beats stall
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'hC, 4'hC};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 4'hF, 4'hF};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 4'hF, 4'h0};  // reset beats stall
    vecs[12] = '{1'b0, 1'b1, 1'b1, 4'h5, 4'h0};  // reset beats everything
    vecs[13] = '{1'b1, 1'b0, 1'b0, 4'h1, 4'h1};  // tied-off stepping
    vecs[14] = '{1'b1, 1'b0, 1'b0, 4'h2, 4'h2};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 4'h4, 4'h4};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 4'h8, 4'h8};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 4'h6, 4'h6};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 4'hB, 4'h0};  // clear alone

    rst_n4 = 1'b1; clear4 = 1'b0; stall4 = 1'b0; d4 = 4'h0;
    rst_n8 = 1'b1; clear8 = 1'b0; stall8 = 1'b0; d8 = 8'h00;
    rst_n64 = 1'b1; d64 = 64'h0;

    // Table: drive at negedge, confirm q has not moved yet, then check just after the edge.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst_n4 = vecs[i].rst_n;
      clear4 = vecs[i].clear;
      stall4 = vecs[i].stall;
      d4     = vecs[i].d;
      #1;
      if (i > 0) check($sformatf("hold_before_edge[%0d]", i), {60'h0, q4}, {60'h0, vecs[i-1].exp_q});
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]", i), {60'h0, q4}, {60'h0, vecs[i].exp_q});
    end

    // Non-zero INIT held across two reset edges.
    @(negedge clk);
    rst_n8 = 1'b0; d8 = 8'hFF;
    @(posedge clk); #1;
    check("init8_reset_edge1", {56'h0, q8}, 64'h5A);
    @(posedge clk); #1;
    check("init8_reset_edge2", {56'h0, q8}, 64'h5A);
    @(negedge clk);
    rst_n8 = 1'b1; d8 = 8'h3C;
    @(posedge clk); #1;
    check("init8_release_load", {56'h0, q8}, 64'h3C);

    // Reset pulse entirely between edges must not disturb q; d is unchanged so q stays 3C.
    @(negedge clk);
    rst_n8 = 1'b0;
    #2;
    check("init8_pulse_async", {56'h0, q8}, 64'h3C);
    rst_n8 = 1'b1;
    @(posedge clk); #1;
    check("init8_pulse_no_effect", {56'h0, q8}, 64'h3C);

    // Clear loads the non-zero INIT, then normal loading resumes.
    @(negedge clk);
    clear8 = 1'b1; d8 = 8'hA5;
    @(posedge clk); #1;
    check("init8_clear", {56'h0, q8}, 64'h5A);
    @(negedge clk);
    clear8 = 1'b0;
    @(posedge clk); #1;
    check("init8_after_clear", {56'h0, q8}, 64'hA5);

    // 64-bit tied-off instance.
    @(negedge clk);
    rst_n64 = 1'b0; d64 = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    check("w64_reset", q64, 64'h0);
    @(negedge clk);
    rst_n64 = 1'b1; d64 = 64'hDEAD_BEEF_0123_4567;
    #1;
    check("w64_no_comb_path", q64, 64'h0);
    @(posedge clk); #1;
    check("w64_load", q64, 64'hDEAD_BEEF_0123_4567);
    @(negedge clk);
    d64 = 64'h8000_0000_0000_0001;
    @(posedge clk); #1;
    check("w64_load2", q64, 64'h8000_0000_0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
